// File: rtl/keccak_pkg.sv
// Shared types and sizing for the keccak byte-stream front end.
// Lane 0 of a word is the most significant byte (bits [31:24]).
package keccak_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = 8;
    localparam int BYTE_NUM_W = 2;
    localparam int WORD_W     = WORD_BYTES * LANE_W;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        PACK,
        FLUSH,
        WAIT
    } state_e;

    function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0]     w,
                                                   input logic [BYTE_NUM_W-1:0] lane,
                                                   input logic [LANE_W-1:0]     b);
        logic [WORD_W-1:0] r;
        r = w;
        case (lane)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    // Fill every lane after 'lane' with the pad value.
    function automatic logic [WORD_W-1:0] pad_after(input logic [WORD_W-1:0]     w,
                                                    input logic [BYTE_NUM_W-1:0] lane,
                                                    input logic [LANE_W-1:0]     pad);
        logic [WORD_W-1:0] r;
        case (lane)
            2'd0:    r = {w[31:24], {3{pad}}};
            2'd1:    r = {w[31:16], {2{pad}}};
            2'd2:    r = {w[31:8], pad};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keccak_byte_packer_if.sv
// Byte-stream input and keccak core word interface of the packer.
// master = packer side, slave = byte source / core side.
interface keccak_byte_packer_if;
    import keccak_pkg::*;

    logic [LANE_W-1:0]     s_byte;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic                  k_reset;
    logic [WORD_W-1:0]     k_in;
    logic                  k_in_ready;
    logic                  k_is_last;
    logic [BYTE_NUM_W-1:0] k_byte_num;
    logic                  k_buffer_full;
    logic                  k_out_ready;
    logic                  busy;

    modport master (
        input  s_byte, s_valid, s_last, k_buffer_full, k_out_ready,
        output s_ready, k_reset, k_in, k_in_ready, k_is_last, k_byte_num, busy
    );

    modport slave (
        output s_byte, s_valid, s_last, k_buffer_full, k_out_ready,
        input  s_ready, k_reset, k_in, k_in_ready, k_is_last, k_byte_num, busy
    );

endinterface

// File: rtl/keccak_byte_packer.sv
// Packs a valid/ready byte stream MSB-first into 32-bit keccak words, one core reset per message.
// Latency: word strobe 1 clk after its last byte (2 clk for a message's first byte); k_buffer_full stalls s_ready while a word is held.
module keccak_byte_packer
    import keccak_pkg::*;
#(
    parameter logic [LANE_W-1:0] PAD_BYTE = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    keccak_byte_packer_if.master bus
);

    localparam logic [BYTE_NUM_W-1:0] LAST_LANE = BYTE_NUM_W'(WORD_BYTES - 1);

    state_e                state_q, state_d;
    logic [WORD_W-1:0]     acc_q, acc_d;
    logic [BYTE_NUM_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [BYTE_NUM_W-1:0] bnum_q, bnum_d;
    logic                  last_q, last_d;
    logic                  word_valid_q, word_valid_d;
    logic                  done_q, done_d;
    logic                  flush_q, flush_d;
    logic                  k_reset_q, k_reset_d;
    logic                  busy_q, busy_d;

    logic                  s_ready;
    logic                  fire_out;
    logic                  accept;
    logic [WORD_W-1:0]     acc_w;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        bnum_d       = bnum_q;
        last_d       = last_q;
        word_valid_d = word_valid_q;
        done_d       = done_q;
        flush_d      = flush_q;
        k_reset_d    = 1'b0;
        s_ready      = 1'b0;

        fire_out = word_valid_q & ~bus.k_buffer_full;

        // k_reset_q is only high in IDLE straight after reset, which keeps s_ready low until release.
        case (state_q)
            IDLE:    s_ready = ~k_reset_q;
            PACK:    s_ready = ~done_q & (~word_valid_q | ~bus.k_buffer_full);
            default: s_ready = 1'b0;
        endcase

        accept = bus.s_valid & s_ready;
        acc_w  = put_lane(acc_q, cnt_q, bus.s_byte);

        if (fire_out) begin
            word_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d     = bus.s_last ? pad_after(put_lane('0, 2'd0, bus.s_byte), 2'd0, PAD_BYTE)
                                           : put_lane('0, 2'd0, bus.s_byte);
                    cnt_d     = 2'd1;
                    done_d    = bus.s_last;
                    flush_d   = 1'b0;
                    k_reset_d = 1'b1;
                    state_d   = RST;
                end
            end
            RST: begin
                state_d = PACK;
                // A one-byte message is held in acc until the core reset has been issued.
                if (done_q) begin
                    word_d       = acc_q;
                    last_d       = 1'b1;
                    bnum_d       = 2'd1;
                    word_valid_d = 1'b1;
                    acc_d        = '0;
                    cnt_d        = '0;
                end
            end
            PACK: begin
                if (accept) begin
                    if (bus.s_last && cnt_q != LAST_LANE) begin
                        word_d       = pad_after(acc_w, cnt_q, PAD_BYTE);
                        last_d       = 1'b1;
                        bnum_d       = cnt_q + 2'd1;
                        word_valid_d = 1'b1;
                        done_d       = 1'b1;
                        acc_d        = '0;
                        cnt_d        = '0;
                    end else if (cnt_q == LAST_LANE) begin
                        word_d       = acc_w;
                        last_d       = 1'b0;
                        bnum_d       = '0;
                        word_valid_d = 1'b1;
                        done_d       = bus.s_last;
                        flush_d      = bus.s_last;
                        acc_d        = '0;
                        cnt_d        = '0;
                    end else begin
                        acc_d = acc_w;
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (done_q && fire_out) begin
                    if (flush_q) begin
                        // Message ended on a word boundary: follow with an empty last word.
                        word_d       = '0;
                        last_d       = 1'b1;
                        bnum_d       = '0;
                        word_valid_d = 1'b1;
                        flush_d      = 1'b0;
                        state_d      = FLUSH;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            FLUSH: begin
                if (fire_out) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.k_out_ready) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            bnum_q       <= '0;
            last_q       <= 1'b0;
            word_valid_q <= 1'b0;
            done_q       <= 1'b0;
            flush_q      <= 1'b0;
            k_reset_q    <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            bnum_q       <= bnum_d;
            last_q       <= last_d;
            word_valid_q <= word_valid_d;
            done_q       <= done_d;
            flush_q      <= flush_d;
            k_reset_q    <= k_reset_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.k_reset    = k_reset_q;
    assign bus.k_in       = word_q;
    assign bus.k_in_ready = fire_out;
    assign bus.k_is_last  = fire_out & last_q;
    assign bus.k_byte_num = bnum_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Directed bench for keccak_byte_packer: two instances (pad 00 / pad FF) share one stimulus stream.
module tb_keccak_byte_packer;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0]  msg [0:63];
    logic [31:0] wq[$];
    logic        lq[$];
    logic [1:0]  bq[$];
    int          cq[$];
    int          rq[$];
    logic [31:0] fq[$];

    keccak_byte_packer_if bus();
    keccak_byte_packer_if bus_ff();

    assign bus_ff.s_byte        = bus.s_byte;
    assign bus_ff.s_valid       = bus.s_valid;
    assign bus_ff.s_last        = bus.s_last;
    assign bus_ff.k_buffer_full = bus.k_buffer_full;
    assign bus_ff.k_out_ready   = bus.k_out_ready;

    keccak_byte_packer #(.PAD_BYTE(8'h00)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    keccak_byte_packer #(.PAD_BYTE(8'hFF)) dut_ff (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_ff)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.k_in_ready) begin
            wq.push_back(bus.k_in);
            lq.push_back(bus.k_is_last);
            bq.push_back(bus.k_byte_num);
            cq.push_back(cyc);
        end
        if (bus_ff.k_in_ready) fq.push_back(bus_ff.k_in);
        if (reset_n && bus.k_reset) rq.push_back(cyc);
    end

    task automatic set_msg(input string s);
        for (int i = 0; i < s.len(); i++) msg[i] = s[i];
    endtask

    task automatic clear_mon();
        wq.delete(); lq.delete(); bq.delete(); cq.delete(); rq.delete(); fq.delete();
    endtask

    task automatic drive_msg(input int n, input bit last_en, output int t0);
        int i;
        int guard;
        i = 0;
        guard = 0;
        t0 = -1;
        while (i < n && guard < 500) begin
            bus.s_valid = 1'b1;
            bus.s_byte  = msg[i];
            bus.s_last  = last_en && (i == n - 1);
            @(negedge clk);
            if (bus.s_ready) begin
                if (i == 0) t0 = cyc;
                i++;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        checks++;
        if (i != n) begin
            failures++;
            $display("FAIL drive_timeout accepted=%0d required=%0d", i, n);
        end
    endtask

    task automatic finish_msg();
        bus.k_out_ready = 1'b1;
        @(posedge clk); #1;
        bus.k_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (bus.k_reset !== 1'b1) begin failures++; $display("FAIL rst_k_reset got=%b exp=1", bus.k_reset); end
        checks++; if (bus.k_in !== 32'h0) begin failures++; $display("FAIL rst_k_in got=%h exp=0", bus.k_in); end
        checks++; if (bus.k_in_ready !== 1'b0) begin failures++; $display("FAIL rst_k_in_ready got=%b exp=0", bus.k_in_ready); end
        checks++; if (bus.k_is_last !== 1'b0) begin failures++; $display("FAIL rst_k_is_last got=%b exp=0", bus.k_is_last); end
        checks++; if (bus.k_byte_num !== 2'd0) begin failures++; $display("FAIL rst_byte_num got=%0d exp=0", bus.k_byte_num); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.k_reset !== 1'b0) begin failures++; $display("FAIL rel_k_reset got=%b exp=0", bus.k_reset); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL rel_s_ready got=%b exp=1", bus.s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_hello();
        int t0;
        logic [31:0] exp_w [4];
        logic        exp_l [4];
        logic [31:0] g;
        logic        gl;
        exp_w = '{32'h48656C6C, 32'h6F2C2077, 32'h6F726C64, 32'h21000000};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        clear_mon();
        set_msg("Hello, world!");
        drive_msg(13, 1'b1, t0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (wq.size() != 4) begin failures++; $display("FAIL hello_count got=%0d exp=4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            g  = (i < wq.size()) ? wq[i] : 32'hx;
            gl = (i < lq.size()) ? lq[i] : 1'bx;
            checks++; if (g !== exp_w[i]) begin failures++; $display("FAIL hello_word%0d got=%h exp=%h", i, g, exp_w[i]); end
            checks++; if (gl !== exp_l[i]) begin failures++; $display("FAIL hello_last%0d got=%b exp=%b", i, gl, exp_l[i]); end
        end
        checks++; if (bq.size() < 4 || bq[3] !== 2'd1) begin failures++; $display("FAIL hello_byte_num got=%0d exp=1", (bq.size() > 3) ? bq[3] : 2'bx); end
        checks++; if (rq.size() != 1 || rq[0] != t0 + 1) begin failures++; $display("FAIL hello_k_reset pulses=%0d first=%0d exp_cycle=%0d", rq.size(), (rq.size() > 0) ? rq[0] : -1, t0 + 1); end
        checks++; if (cq.size() < 4 || cq[0] != t0 + 5 || cq[3] != t0 + 14) begin failures++; $display("FAIL hello_timing got=%0d/%0d exp=%0d/%0d", (cq.size() > 0) ? cq[0] : -1, (cq.size() > 3) ? cq[3] : -1, t0 + 5, t0 + 14); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL hello_busy_wait got=%b exp=1", bus.busy); end
        @(posedge clk); #1;
        finish_msg();
    endtask

    task automatic test_hell_last();
        int t0;
        clear_mon();
        set_msg("Hell");
        drive_msg(4, 1'b1, t0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (wq.size() != 2) begin failures++; $display("FAIL hell_count got=%0d exp=2", wq.size()); end
        checks++; if (wq.size() < 1 || wq[0] !== 32'h48656C6C || lq[0] !== 1'b0) begin failures++; $display("FAIL hell_word0 got=%h last=%b exp=48656c6c last=0", (wq.size() > 0) ? wq[0] : 32'hx, (lq.size() > 0) ? lq[0] : 1'bx); end
        checks++; if (wq.size() < 2 || wq[1] !== 32'h0 || lq[1] !== 1'b1 || bq[1] !== 2'd0) begin failures++; $display("FAIL hell_flush got=%h last=%b exp=00000000 last=1 bn=0", (wq.size() > 1) ? wq[1] : 32'hx, (lq.size() > 1) ? lq[1] : 1'bx); end
        checks++; if (cq.size() < 2 || cq[1] != cq[0] + 1) begin failures++; $display("FAIL hell_flush_timing got=%0d exp=%0d", (cq.size() > 1) ? cq[1] : -1, (cq.size() > 0) ? cq[0] + 1 : -1); end
        @(posedge clk); #1;
        finish_msg();
    endtask

    task automatic test_single();
        int t0;
        clear_mon();
        set_msg("A");
        drive_msg(1, 1'b1, t0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (rq.size() != 1 || rq[0] != t0 + 1) begin failures++; $display("FAIL single_k_reset got=%0d exp=%0d", (rq.size() > 0) ? rq[0] : -1, t0 + 1); end
        checks++; if (cq.size() != 1 || cq[0] != t0 + 2) begin failures++; $display("FAIL single_timing got=%0d exp=%0d", (cq.size() > 0) ? cq[0] : -1, t0 + 2); end
        checks++; if (wq.size() != 1 || wq[0] !== 32'h41000000 || bq[0] !== 2'd1 || lq[0] !== 1'b1) begin failures++; $display("FAIL single_word got=%h exp=41000000 bn=1 last=1", (wq.size() > 0) ? wq[0] : 32'hx); end
        checks++; if (fq.size() != 1 || fq[0] !== 32'h41FFFFFF) begin failures++; $display("FAIL single_pad_ff got=%h exp=41ffffff", (fq.size() > 0) ? fq[0] : 32'hx); end
        @(posedge clk); #1;
        finish_msg();
    endtask

    task automatic test_backpressure();
        int t0;
        int rel;
        logic [31:0] exp_w [4];
        logic [31:0] g;
        exp_w = '{32'h48656C6C, 32'h6F2C2077, 32'h6F726C64, 32'h21000000};
        rel = -1;
        clear_mon();
        set_msg("Hello, world!");
        fork
            drive_msg(13, 1'b1, t0);
            begin
                int guard;
                guard = 0;
                while (wq.size() < 1 && guard < 200) begin
                    @(negedge clk); #1;
                    guard++;
                end
                repeat (4) @(posedge clk);
                #1;
                bus.k_buffer_full = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checks++; if (bus.k_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d got=%b exp=0", k, bus.k_in_ready); end
                    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready%0d got=%b exp=0", k, bus.s_ready); end
                    checks++; if (bus.k_in !== 32'h6F2C2077) begin failures++; $display("FAIL bp_hold%0d got=%h exp=6f2c2077", k, bus.k_in); end
                end
                @(posedge clk); #1;
                bus.k_buffer_full = 1'b0;
                rel = cyc;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wq.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < wq.size()) ? wq[i] : 32'hx;
            checks++; if (g !== exp_w[i]) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, g, exp_w[i]); end
        end
        checks++; if (cq.size() < 2 || cq[1] != rel) begin failures++; $display("FAIL bp_release got=%0d exp=%0d", (cq.size() > 1) ? cq[1] : -1, rel); end
        finish_msg();
    endtask

    task automatic test_reset_mid();
        int t0;
        set_msg("Hello, world!");
        drive_msg(6, 1'b0, t0);
        clear_mon();
        reset_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.k_reset !== 1'b1) begin failures++; $display("FAIL mid_k_reset got=%b exp=1", bus.k_reset); end
        checks++; if (bus.k_in !== 32'h0) begin failures++; $display("FAIL mid_k_in got=%h exp=0", bus.k_in); end
        checks++; if (bus.busy !== 1'b0 || bus.k_byte_num !== 2'd0 || bus.k_is_last !== 1'b0) begin failures++; $display("FAIL mid_outputs busy=%b bn=%0d last=%b exp=0/0/0", bus.busy, bus.k_byte_num, bus.k_is_last); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (wq.size() != 0) begin failures++; $display("FAIL mid_no_strobe got=%0d exp=0", wq.size()); end
        clear_mon();
        set_msg("1234567890");
        drive_msg(10, 1'b1, t0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wq.size() != 3) begin failures++; $display("FAIL mid_count got=%0d exp=3", wq.size()); end
        checks++; if (wq.size() < 2 || wq[0] !== 32'h31323334 || wq[1] !== 32'h35363738) begin failures++; $display("FAIL mid_words got=%h,%h exp=31323334,35363738", (wq.size() > 0) ? wq[0] : 32'hx, (wq.size() > 1) ? wq[1] : 32'hx); end
        checks++; if (wq.size() < 3 || wq[2] !== 32'h39300000 || bq[2] !== 2'd2 || lq[2] !== 1'b1) begin failures++; $display("FAIL mid_last got=%h exp=39300000 bn=2 last=1", (wq.size() > 2) ? wq[2] : 32'hx); end
        finish_msg();
    endtask

    task automatic test_out_ready();
        int t0;
        int t1;
        clear_mon();
        set_msg("Hi!");
        fork
            drive_msg(3, 1'b1, t0);
            begin
                repeat (2) @(posedge clk);
                #1;
                bus.k_out_ready = 1'b1;
                @(posedge clk); #1;
                bus.k_out_ready = 1'b0;
            end
        join
        @(posedge clk); #1;
        bus.k_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.s_ready !== 1'b0) begin failures++; $display("FAIL or_wait busy=%b s_ready=%b exp=1/0", bus.busy, bus.s_ready); end
        checks++; if (wq.size() != 1 || wq[0] !== 32'h48692100 || bq[0] !== 2'd3 || lq[0] !== 1'b1) begin failures++; $display("FAIL or_word got=%h exp=48692100 bn=3 last=1", (wq.size() > 0) ? wq[0] : 32'hx); end
        @(posedge clk); #1;
        bus.k_out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.s_ready !== 1'b1) begin failures++; $display("FAIL or_idle busy=%b s_ready=%b exp=0/1", bus.busy, bus.s_ready); end
        @(posedge clk); #1;
        set_msg("A");
        drive_msg(1, 1'b1, t1);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rq.size() != 2 || rq[0] != t0 + 1 || rq[1] != t1 + 1) begin failures++; $display("FAIL or_b2b_k_reset pulses=%0d exp=2 at %0d,%0d", rq.size(), t0 + 1, t1 + 1); end
        @(posedge clk); #1;
        finish_msg();
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.s_byte        = 8'h00;
        bus.s_valid       = 1'b0;
        bus.s_last        = 1'b0;
        bus.k_buffer_full = 1'b0;
        bus.k_out_ready   = 1'b0;
        test_reset();
        test_hello();
        test_hell_last();
        test_single();
        test_backpressure();
        test_reset_mid();
        test_out_ready();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_byte_packer.md
# keccak_byte_packer

Byte-stream front end for the `keccak` hashing core. It accepts one message byte per cycle over a valid/ready handshake and packs bytes MSB-first into 32-bit words. It drives the core's `in`/`in_ready`/`is_last`/`byte_num` word interface, honours `buffer_full` backpressure, and issues the per-message core reset. It then holds off the next message until the core raises `out_ready`.

## Interface
- `PAD_BYTE`, default `8'h00`: fill value for unused lanes of a partial last word.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `s_byte`  in  8  message byte.
- `s_valid`  in  1  `s_byte` valid.
- `s_last`  in  1  this byte is the final byte of the message.
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`.
- `k_reset`  out  1  active-high reset to the core; one-cycle pulse per message.
- `k_in`  out  32  packed word; byte lane 0 = bits [31:24].
- `k_in_ready`  out  1  word strobe to the core.
- `k_is_last`  out  1  final word of the message.
- `k_byte_num`  out  2  valid bytes in the final word (0..3).
- `k_buffer_full`  in  1  core cannot take a word this cycle.
- `k_out_ready`  in  1  digest complete.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- **States:**
  - **IDLE:** `s_ready=1`. An accepted byte goes to lane 0 of `acc` (`cnt=1`, or last handling) -> RST.
  - **RST:** `k_reset=1` for exactly one cycle, `s_ready=0` -> PACK.
  - **PACK:** `s_ready = !word_valid | !k_buffer_full`. Each accepted byte is written to lane `cnt`, then `cnt++`.
  - **FLUSH:** emits the empty last word -> WAIT.
  - **WAIT:** `s_ready=0`. `k_out_ready=1` -> IDLE.
- **Full word** (4th byte, no `s_last`): `acc` moves to the output register with `word_valid=1`, `last=0`, and `cnt` wraps to 0.
- **`s_last` on byte with `cnt` 0..2 before the write:** emit word with `last=1`, `byte_num=cnt+1`, unused lanes = `PAD_BYTE`. After it is consumed -> WAIT.
- **`s_last` on 4th byte:** emit the full word (`last=0`), then in FLUSH emit `k_in=0`, `last=1`, `byte_num=0`.
- **Output gating (combinational):**
  - `k_in_ready = word_valid & !k_buffer_full`.
  - `k_is_last = k_in_ready & out_last`.
  - `word_valid` clears on the edge where `k_in_ready=1`.
  - `k_in` and `k_byte_num` are held stable while `word_valid=1`.
- **Out-of-state inputs:** `k_out_ready` outside WAIT is ignored. Unaccepted bytes must be held by the source.
- **Reset values:**
  - State IDLE; `acc=0`, `cnt=0`, `word_valid=0`.
  - `k_in=0`, `k_in_ready=0`, `k_is_last=0`, `k_byte_num=0`, `busy=0`.
  - `k_reset=1` (the core is held in reset with the packer). `k_reset` clears on the first cycle after `reset_n` rises.
  - `s_ready=1` from the first cycle after release.
- **Reset mid-message:** partial `acc` and any pending word are discarded, no `k_in_ready` is issued, and the state returns to IDLE.

## Timing
- First byte accepted at cycle t: `k_reset` high in t+1; earliest `k_in_ready` in t+2.
- Word-completing byte accepted at t: `k_in_ready` earliest at t+1. Sustained throughput is 1 byte/clk with `k_buffer_full=0`.
- FLUSH word appears the cycle after the full word is consumed, gated by `k_buffer_full`.
- WAIT -> IDLE: `k_out_ready` sampled at t means `s_ready=1` at t+1.
- While `k_buffer_full=1` with `word_valid=1`: `s_ready=0` and the word is held unchanged.

## Structure
- Shared package `keccak_pkg` holds:
  - state enum (`IDLE`, `RST`, `PACK`, `FLUSH`, `WAIT`);
  - `WORD_BYTES=4`, `LANE_W=8`, `BYTE_NUM_W=2`.
- Single module; no sub-module. The accumulator and output register are inline.

## Test plan
1. **"Hello, world!"** (13 bytes, continuous valid, `k_buffer_full=0`) -> one `k_reset` pulse, then words `"Hell"`, `"o, w"`, `"orld"`, then `32'h21000000` with `k_is_last=1`, `k_byte_num=1`. `busy` stays high until `k_out_ready`.
2. **"Hell"** with `s_last` on byte 4 -> `"Hell"` with `k_is_last=0`, next cycle `32'h0`, `k_is_last=1`, `k_byte_num=0`.
3. **Single byte `"A"`:**
   - Stimulus: one byte with `s_last`.
   - `k_reset` in t+1.
   - `32'h41000000`, `k_byte_num=1` in t+2.
   - With `PAD_BYTE=8'hFF`, the word is `32'h41FFFFFF`.
4. **Backpressure:** `k_buffer_full` high 5 cycles while word `"o, w"` is pending -> `k_in_ready=0`, `s_ready=0`, `k_in` stable. The word is issued on the first low cycle with no byte lost or duplicated.
5. **Reset mid-message:** `reset_n` low after 6 bytes -> all outputs at reset values, `k_reset=1`. Next message `"1234567890"` then produces `"1234"`, `"5678"`, `32'h39300000` with `byte_num=2`.
6. **`k_out_ready` timing:** pulse during PACK is ignored; pulse in WAIT gives `s_ready=1` and `busy=0` next cycle. A back-to-back second message gets its own `k_reset`.
